brew_sequence_ctrl: RTL and testbench

- Sequences one drink cycle of the coffee machine (heat → brew → optional milk → done) on a local 1 s time base.
- Owns the single prescaler that produces the seconds tick, restarting it so every stage starts on a full second.
- Drives the heater, pump and milk valve enables, plus a seconds countdown for the display multiplexer.
- Sits between the user-input logic and the actuator and display blocks.

---
 rtl/coffee_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/brew_sequence_ctrl.sv | 104 ++++++++++
 tb/tb_brew_sequence_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// Shared types and default timing for the coffee machine.
// Stage encoding is visible on the display bus.
package coffee_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAT = 3'd1,
    S_BREW = 3'd2,
    S_MILK = 3'd3,
    S_DONE = 3'd4
  } stage_t;

  localparam int CLK_HZ = 50_000_000;
  localparam int T_HEAT = 5;
  localparam int T_BREW = 10;
  localparam int T_MILK = 4;
  localparam int T_DONE = 3;

endpackage

// File: rtl/tick_prescaler.sv
// Seconds prescaler: counts 0..DIV-1 while enabled.
// A clear restarts the second so stages begin on a full tick.
module tick_prescaler #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else cnt <= cnt + W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/brew_sequence_ctrl.sv
// Drink-cycle sequencer: heat, brew, optional milk, done.
// One actuator per state, so at most one is ever on.
module brew_sequence_ctrl
  import coffee_pkg::*;
#(
  parameter int TICK_DIV = CLK_HZ,
  parameter int T_HEAT   = coffee_pkg::T_HEAT,
  parameter int T_BREW   = coffee_pkg::T_BREW,
  parameter int T_MILK   = coffee_pkg::T_MILK,
  parameter int T_DONE   = coffee_pkg::T_DONE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel_milk,
  input  logic       cancel,
  output logic       tick_1hz,
  output logic       heater_on,
  output logic       pump_on,
  output logic       milk_on,
  output logic       done,
  output logic       busy,
  output logic [2:0] stage,
  output logic [7:0] remaining
);

  stage_t     state, state_n;
  logic [7:0] rem, rem_n;
  logic       milk, milk_n;
  logic       tick, clr;

  tick_prescaler #(.DIV(TICK_DIV)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    rem_n   = rem;
    milk_n  = milk;
    clr     = 1'b0;
    if (state == S_IDLE) begin
      if (start && !cancel) begin
        state_n = S_HEAT;
        rem_n   = 8'(T_HEAT);
        milk_n  = sel_milk;
        clr     = 1'b1;
      end
    end else if (cancel) begin
      state_n = S_IDLE;
      rem_n   = '0;
      clr     = 1'b1;
    end else if (tick) begin
      if (rem > 8'd1) begin
        rem_n = rem - 8'd1;
      end else begin
        clr = 1'b1;
        unique case (state)
          S_HEAT: begin
            state_n = S_BREW;
            rem_n   = 8'(T_BREW);
          end
          S_BREW: begin
            state_n = milk ? S_MILK : S_DONE;
            rem_n   = milk ? 8'(T_MILK) : 8'(T_DONE);
          end
          S_MILK: begin
            state_n = S_DONE;
            rem_n   = 8'(T_DONE);
          end
          default: begin
            state_n = S_IDLE;
            rem_n   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rem   <= '0;
      milk  <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      milk  <= milk_n;
    end
  end

  assign busy      = (state != S_IDLE);
  assign tick_1hz  = tick;
  assign heater_on = (state == S_HEAT);
  assign pump_on   = (state == S_BREW);
  assign milk_on   = (state == S_MILK);
  assign done      = (state == S_DONE);
  assign stage     = state;
  assign remaining = rem;

endmodule

// File: tb/tb_brew_sequence_ctrl.sv
// Bench for brew_sequence_ctrl: directed scenarios then random
// traffic, checked against a timeline model of the drink cycle.
module tb_brew_sequence_ctrl;

  localparam int DIV = 4;
  localparam int TH  = 2;
  localparam int TB  = 3;
  localparam int TM  = 2;
  localparam int TD  = 1;

  logic       clk = 1'b0;
  logic       rst, start, sel_milk, cancel;
  logic       tick_1hz, heater_on, pump_on, milk_on, done, busy;
  logic [2:0] stage;
  logic [7:0] remaining;

  int checks = 0;
  int errors = 0;

  // model: active drink, cycles since accept, milk option
  bit act = 1'b0;
  int k   = 0;
  bit mm  = 1'b0;

  brew_sequence_ctrl #(
    .TICK_DIV (DIV),
    .T_HEAT   (TH),
    .T_BREW   (TB),
    .T_MILK   (TM),
    .T_DONE   (TD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sel_milk  (sel_milk),
    .cancel    (cancel),
    .tick_1hz  (tick_1hz),
    .heater_on (heater_on),
    .pump_on   (pump_on),
    .milk_on   (milk_on),
    .done      (done),
    .busy      (busy),
    .stage     (stage),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)",
               tag, got, exp, k, $time);
    end
  endtask

  // Expected outputs from the stage list and elapsed cycles.
  task automatic model(output int st, output int rm, output bit tk);
    int sid[4];
    int dur[4];
    int n, base;
    st = 0; rm = 0; tk = 1'b0;
    if (!act) return;
    n = 0;
    sid[n] = 1; dur[n] = TH; n++;
    sid[n] = 2; dur[n] = TB; n++;
    if (mm) begin sid[n] = 3; dur[n] = TM; n++; end
    sid[n] = 4; dur[n] = TD; n++;
    base = 0;
    for (int i = 0; i < n; i++) begin
      if (k < base + dur[i] * DIV) begin
        st = sid[i];
        rm = dur[i] - (k - base) / DIV;
        tk = ((k - base) % DIV) == DIV - 1;
        return;
      end
      base += dur[i] * DIV;
    end
  endtask

  function automatic int total_len();
    return (TH + TB + (mm ? TM : 0) + TD) * DIV;
  endfunction

  task automatic check_all();
    int st, rm;
    bit tk;
    model(st, rm, tk);
    chk("stage", 8'(stage), 8'(st));
    chk("remaining", remaining, 8'(rm));
    chk("tick_1hz", 8'(tick_1hz), 8'(tk));
    chk("busy", 8'(busy), 8'(st != 0));
    chk("heater_on", 8'(heater_on), 8'(st == 1));
    chk("pump_on", 8'(pump_on), 8'(st == 2));
    chk("milk_on", 8'(milk_on), 8'(st == 3));
    chk("done", 8'(done), 8'(st == 4));
  endtask

  // Check current outputs, apply inputs, advance one edge.
  task automatic cyc(input bit s, input bit m, input bit c, input bit r);
    @(negedge clk);
    check_all();
    start = s; sel_milk = m; cancel = c; rst = r;
    @(posedge clk);
    if (r) begin
      act = 1'b0;
    end else if (act) begin
      if (c) act = 1'b0;
      else begin
        k++;
        if (k >= total_len()) act = 1'b0;
      end
    end else if (s && !c) begin
      act = 1'b1; k = 0; mm = m;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    start = 0; sel_milk = 0; cancel = 0; rst = 1;
    @(posedge clk);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    // plain drink
    cyc(1, 0, 0, 0);
    idle(30);
    // milk drink, sel_milk toggled mid-cycle
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 34; i++) cyc(0, i[0], 0, 0);
    // cancel on the tick in BREW with remaining 2
    cyc(1, 0, 0, 0);
    idle(15);
    cyc(0, 0, 1, 0);
    idle(10);
    // start again during HEAT
    cyc(1, 1, 0, 0);
    idle(3);
    cyc(1, 1, 0, 0);
    idle(27);
    // start with cancel in IDLE, then start alone
    cyc(1, 0, 1, 0);
    idle(2);
    cyc(1, 0, 0, 0);
    idle(30);
    // reset during MILK, then full cycle
    cyc(1, 1, 0, 0);
    idle(22);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 0);
    idle(40);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 7) == 0,
          1'($urandom),
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    check_all();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
